score_text_line_fetcher: RTL and testbench

//  Sequences the 96x8 "SCORE:" font ROM (6 glyphs x 16 rows, 8-bit address, async read) for the VGA path.
//  On every horizontal-blank start it fetches the 6 glyph bytes of the upcoming scanline into a line buffer.

---
 rtl/score_text_line_fetcher.sv | 154 +++++++++++++++
 tb/tb_score_text_line_fetcher.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/score_text_line_fetcher.sv
// Font-ROM sequencer for the "SCORE:" text box. It prefetches one scanline of glyph bytes
// during horizontal blank, then serialises them into a registered text_on pixel stream.
module score_text_line_fetcher #(
  parameter logic [9:0] TEXT_X     = 10'd16,
  parameter logic [9:0] TEXT_Y     = 10'd8,
  parameter int         NUM_GLYPHS = 6,
  parameter int         GLYPH_H    = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       line_start,
  input  logic [9:0] next_y,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       text_on,
  output logic       busy
);

  localparam int             IDX_W     = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
  localparam int             ROW_W     = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GLYPHS - 1);
  localparam logic [7:0]     ADDR_STEP = 8'(GLYPH_H);
  localparam logic [9:0]     BOX_H     = 10'(GLYPH_H);
  localparam logic [9:0]     BOX_W     = 10'(NUM_GLYPHS * 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_rom_addr;
  logic             r_text_on;
  logic             r_line_valid;
  logic [9:0]       r_line_y;
  logic [ROW_W-1:0] r_row;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_buf [NUM_GLYPHS];

  state_t           w_state_nxt;
  logic [7:0]       w_rom_addr_nxt;
  logic             w_line_valid_nxt;
  logic [9:0]       w_line_y_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_buf_we;
  logic [9:0]       w_y_off;
  logic             w_in_box;
  logic [9:0]       w_dx;
  logic             w_in_x;
  logic             w_pix;
  logic             w_text_on_nxt;

  assign w_y_off  = next_y - TEXT_Y;
  assign w_in_box = (next_y >= TEXT_Y) && (w_y_off < BOX_H);
  assign w_dx     = DrawX - TEXT_X;
  assign w_in_x   = (DrawX >= TEXT_X) && (w_dx < BOX_W);

  // Next-state and fetch datapath; line_start overrides whatever the FSM is doing.
  always_comb begin
    w_state_nxt      = r_state;
    w_rom_addr_nxt   = r_rom_addr;
    w_line_valid_nxt = r_line_valid;
    w_line_y_nxt     = r_line_y;
    w_row_nxt        = r_row;
    w_idx_nxt        = r_idx;
    w_buf_we         = 1'b0;
    if (line_start) begin
      w_line_valid_nxt = 1'b0;
      if (w_in_box) begin
        w_row_nxt      = w_y_off[ROW_W-1:0];
        w_line_y_nxt   = next_y;
        w_idx_nxt      = '0;
        w_rom_addr_nxt = 8'(w_y_off[ROW_W-1:0]);
        w_state_nxt    = S_FETCH;
      end else begin
        w_rom_addr_nxt = 8'd0;
        w_state_nxt    = S_IDLE;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          w_buf_we = 1'b1;
          // rom_addr already equals idx*GLYPH_H+row, so the next glyph is one stride away
          if (r_idx != LAST_IDX) begin
            w_idx_nxt      = r_idx + 1'b1;
            w_rom_addr_nxt = r_rom_addr + ADDR_STEP;
          end else begin
            w_line_valid_nxt = 1'b1;
            w_rom_addr_nxt   = 8'd0;
            w_state_nxt      = S_READY;
          end
        end
        S_READY: begin
          w_rom_addr_nxt = 8'd0;
        end
        S_IDLE: begin
          w_rom_addr_nxt = 8'd0;
        end
        default: begin
          w_state_nxt      = S_IDLE;
          w_rom_addr_nxt   = 8'd0;
          w_line_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // Pixel select from the line buffer for the current beam position.
  always_comb begin
    w_pix = 1'b0;
    if (w_in_x) begin
      w_pix = r_buf[w_dx[IDX_W+2:3]][3'd7 - w_dx[2:0]];
    end else begin
      w_pix = 1'b0;
    end
    w_text_on_nxt = r_line_valid && (DrawY == r_line_y) && w_pix;
  end

  // State, address, buffer and pixel registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_rom_addr   <= 8'd0;
      r_text_on    <= 1'b0;
      r_line_valid <= 1'b0;
      r_line_y     <= 10'd0;
      r_row        <= '0;
      r_idx        <= '0;
      for (int i = 0; i < NUM_GLYPHS; i++) begin
        r_buf[i] <= 8'd0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_rom_addr   <= w_rom_addr_nxt;
      r_text_on    <= w_text_on_nxt;
      r_line_valid <= w_line_valid_nxt;
      r_line_y     <= w_line_y_nxt;
      r_row        <= w_row_nxt;
      r_idx        <= w_idx_nxt;
      if (w_buf_we) begin
        r_buf[r_idx] <= rom_data;
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign text_on  = r_text_on;
  assign busy     = (r_state == S_FETCH);

endmodule

// File: tb/tb_score_text_line_fetcher.sv
// Scoreboard bench for score_text_line_fetcher: a bench-side font ROM feeds the DUT, expected
// ROM addresses and text_on bits are queued as stimulus is applied and popped as outputs appear.
module tb_score_text_line_fetcher;

  localparam logic [9:0] TEXT_X = 10'd16;
  localparam logic [9:0] TEXT_Y = 10'd8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       line_start;
  logic [9:0] next_y;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       text_on;
  logic       busy;

  logic [7:0] rom [0:95];
  logic [7:0] addr_q [$];
  logic       text_q [$];

  logic       m_valid;
  logic [9:0] m_line_y;
  logic [7:0] m_buf [6];

  int n_cmp = 0;
  int n_bad = 0;

  score_text_line_fetcher dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .line_start (line_start),
    .next_y     (next_y),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .text_on    (text_on),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  assign rom_data = (rom_addr <= 8'd95) ? rom[rom_addr] : 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic exp_pix(input logic [9:0] x, input logic [9:0] y);
    int dx;
    if (!m_valid || y != m_line_y || x < TEXT_X) return 1'b0;
    dx = int'(x) - int'(TEXT_X);
    if (dx >= 48) return 1'b0;
    return m_buf[dx / 8][7 - (dx % 8)];
  endfunction

  task automatic model_load(input int row, input logic [9:0] y);
    for (int g = 0; g < 6; g++) m_buf[g] = rom[g * 16 + row];
    m_valid  = 1'b1;
    m_line_y = y;
  endtask

  task automatic start_line(input logic [9:0] y);
    line_start = 1'b1;
    next_y     = y;
    m_valid    = 1'b0;
    tick();
    line_start = 1'b0;
  endtask

  task automatic expect_fetch(input int row);
    for (int k = 0; k < 6; k++) addr_q.push_back(8'(k * 16 + row));
    for (int k = 0; k < 6; k++) begin
      check_val("fetch_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
      check_val("fetch_busy", 32'(busy), 32'd1);
      tick();
    end
    check_val("done_busy", 32'(busy), 32'd0);
    check_val("done_addr", 32'(rom_addr), 32'd0);
  endtask

  task automatic sweep(input logic [9:0] y);
    for (int x = 0; x < 80; x++) begin
      DrawX = 10'(x);
      DrawY = y;
      text_q.push_back(exp_pix(10'(x), y));
      tick();
      check_val("text_on", 32'(text_on), 32'(text_q.pop_front()));
    end
  endtask

  initial begin
    logic [7:0] row2 [6] = '{8'h7C, 8'h3C, 8'h7C, 8'hFC, 8'hFE, 8'h00};
    logic [7:0] row9 [6] = '{8'hC6, 8'hC0, 8'hC6, 8'h66, 8'h62, 8'h18};
    for (int a = 0; a < 96; a++) rom[a] = 8'(a * 29 + 7) ^ 8'h5A;
    for (int g = 0; g < 6; g++) begin
      rom[g * 16 + 2] = row2[g];
      rom[g * 16 + 9] = row9[g];
    end

    Reset = 1'b1; line_start = 1'b0; next_y = 10'd0; DrawX = 10'd0; DrawY = 10'd0;
    m_valid = 1'b0; m_line_y = 10'd0;
    for (int g = 0; g < 6; g++) m_buf[g] = 8'd0;

    // Test 1: reset then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_addr", 32'(rom_addr), 32'd0);
      check_val("rst_text", 32'(text_on), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
    end
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      DrawX = 10'(16 + i);
      DrawY = TEXT_Y;
      tick();
      check_val("idle_addr", 32'(rom_addr), 32'd0);
      check_val("idle_text", 32'(text_on), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
    end

    // Tests 2/3: fetch row 2 and sweep its line plus the line below
    start_line(TEXT_Y + 10'd2);
    expect_fetch(2);
    model_load(2, TEXT_Y + 10'd2);
    sweep(TEXT_Y + 10'd2);
    sweep(TEXT_Y + 10'd3);

    // Test 4: line below the box leaves the FSM idle and clears the buffer validity
    start_line(TEXT_Y + 10'd16);
    for (int i = 0; i < 8; i++) begin
      check_val("out_addr", 32'(rom_addr), 32'd0);
      check_val("out_busy", 32'(busy), 32'd0);
      tick();
    end
    sweep(TEXT_Y + 10'd16);
    sweep(TEXT_Y + 10'd2);

    // Test 5: restart during the third fetch cycle
    start_line(TEXT_Y + 10'd5);
    check_val("r5_addr0", 32'(rom_addr), 32'd5);
    tick();
    check_val("r5_addr1", 32'(rom_addr), 32'd21);
    tick();
    check_val("r5_addr2", 32'(rom_addr), 32'd37);
    start_line(TEXT_Y + 10'd9);
    expect_fetch(9);
    model_load(9, TEXT_Y + 10'd9);
    sweep(TEXT_Y + 10'd9);

    // Test 6: reset in the middle of a fetch
    start_line(TEXT_Y + 10'd9);
    tick();
    tick();
    tick();
    check_val("r6_addr3", 32'(rom_addr), 32'd57);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_val("r6_busy", 32'(busy), 32'd0);
    check_val("r6_addr", 32'(rom_addr), 32'd0);
    check_val("r6_text", 32'(text_on), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("r6_idle_addr", 32'(rom_addr), 32'd0);
      check_val("r6_idle_busy", 32'(busy), 32'd0);
    end
    sweep(TEXT_Y + 10'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
